game_sequencer: RTL and testbench
=================================

# game_sequencer

Frame-synchronous game-flow controller for the pinball design. It sequences the ball through serve, play, loss and game-over, and owns the pause, ball-hold and launch controls consumed by the smiley and flipper blocks. It converts per-pixel collision pulses from game_controller into at most one scoring event per collision type per frame, and maintains the score and lives counters.

## Interface
Parameters:
- LIVES, 3: balls per game (1..7)
- SERVE_FRAMES, 60: frames the ball is held before auto-launch
- LOST_FRAMES, 90: frames spent in ball-lost delay
- FLIPPER_POINTS, 10: points per frame with a flipper hit
- WALL_POINTS, 1: points per frame with any top/left/right border hit
- SCORE_MAX, 9999: score saturation value

Ports:
- clk  in  1  system pixel clock; the block's only clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- key5IsPressed  in  1  level; start / pause / restart key
- collisionSmileyFlipper  in  1  per-pixel collision pulse
- collisionSmileyBorderTop, collisionSmileyBorderLeft, collisionSmileyBorderRight  in  1 each  per-pixel collision pulses
- collisionSmileyBorderBottom  in  1  per-pixel pulse; ball lost
- pause  out  1  freeze motion of all moving objects
- ballHold  out  1  hold ball at its start position
- launchPulse  out  1  one-cycle pulse at serve release
- score  out  14  current score, binary
- lives  out  3  remaining balls
- gameOver  out  1  high in GAME_OVER
- state  out  3  encoded state (IDLE=0, SERVE=1, PLAY=2, PAUSED=3, LOST=4, GAME_OVER=5)

## Operation
- Key edge: keyPrev registers key5IsPressed; keyEdge = key5IsPressed & ~keyPrev. keyPrev resets to 1 so a key held through reset produces no edge.
- States and transitions:
  - IDLE: keyEdge -> SERVE, load frameCnt = SERVE_FRAMES.
  - SERVE: at each startOfFrame, frameCnt decrements; when frameCnt reaches 0 -> PLAY, with launchPulse asserted in the transition cycle. keyEdge -> PLAY immediately, with launchPulse.
  - PLAY: keyEdge -> PAUSED. At startOfFrame with bottom flag set -> LOST, lives decrements, load frameCnt = LOST_FRAMES.
  - PAUSED: keyEdge -> PLAY; no launchPulse is issued.
  - LOST: at each startOfFrame, frameCnt decrements; at 0 -> GAME_OVER if lives==0, else SERVE with frameCnt = SERVE_FRAMES.
  - GAME_OVER: keyEdge -> IDLE; score cleared to 0, lives reloaded to LIVES.
- Outputs are decoded from the registered state:
  - pause = (state != PLAY)
  - ballHold = state in {IDLE, SERVE, LOST, GAME_OVER}
  - gameOver = (state == GAME_OVER)
- Collision flags: fFlip, fWall and fBottom are sticky bits, set by their pulses only while state==PLAY. fWall is the OR of top, left and right. All flags clear at every startOfFrame and on any exit from PLAY.
- Scoring at startOfFrame in PLAY:
  - score += FLIPPER_POINTS·fFlip + WALL_POINTS·fWall, saturating at SCORE_MAX.
  - Use 15-bit intermediate arithmetic; no wrap.
  - Scoring is applied in the same frame as a bottom loss.
- lives never underflows; a decrement happens only on the PLAY->LOST transition.

## Timing
- Reset values: state=IDLE, lives=LIVES, score=0, frameCnt=0, all flags=0, keyPrev=1, pause=1, ballHold=1, launchPulse=0, gameOver=0.
- All outputs are registered or decoded from registers; they change one clk after the causing input edge.
- A collision pulse in the same cycle as startOfFrame belongs to the next frame: the flag is set after the clear.
- keyEdge and startOfFrame in the same cycle: keyEdge takes priority. Example: SERVE releases via key, and the frame decrement is skipped.
- Reset asserted mid-game returns to IDLE asynchronously within the same cycle; no launchPulse is emitted.
- The first frame-count decrement occurs on the first startOfFrame after entering SERVE or LOST. SERVE therefore lasts exactly SERVE_FRAMES frames.

## Test plan
- Reset, then key5 press with no further input -> state SERVE. After 60 startOfFrame pulses: state=PLAY, launchPulse high for exactly 1 cycle, pause=0.
- In PLAY, 40 flipper pulses plus 5 top-border pulses within one frame, then startOfFrame -> score +11 once. The next frame with no collisions leaves score unchanged.
- Bottom collision in PLAY -> at the next startOfFrame state=LOST and lives 3->2. After 90 frames state=SERVE.
- Lose 3 balls -> GAME_OVER with gameOver=1 and lives=0. A key press then gives IDLE, score=0, lives=3.
- Preload score to 9995, then a flipper hit -> score=9999. Further hits keep it at 9999.
- Key held through reset release -> no transition. Key press in PLAY -> PAUSED and collisions ignored. A second press -> PLAY with no launchPulse.

Source files
------------

// File: rtl/game_sequencer.sv
// Frame-synchronous game-flow controller: serve/play/pause/lost/game-over sequencing,
// per-frame collision scoring with saturation, and lives bookkeeping.
module game_sequencer #(
    parameter int LIVES          = 3,
    parameter int SERVE_FRAMES   = 60,
    parameter int LOST_FRAMES    = 90,
    parameter int FLIPPER_POINTS = 10,
    parameter int WALL_POINTS    = 1,
    parameter int SCORE_MAX      = 9999
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key5IsPressed,
    input  logic        collisionSmileyFlipper,
    input  logic        collisionSmileyBorderTop,
    input  logic        collisionSmileyBorderLeft,
    input  logic        collisionSmileyBorderRight,
    input  logic        collisionSmileyBorderBottom,
    output logic        pause,
    output logic        ballHold,
    output logic        launchPulse,
    output logic [13:0] score,
    output logic [2:0]  lives,
    output logic        gameOver,
    output logic [2:0]  state
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 2);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_LOST      = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_frame_cnt_nxt;
    logic             r_key_prev;
    logic             w_key_edge;
    logic             r_f_flip;
    logic             r_f_wall;
    logic             r_f_bottom;
    logic             w_f_flip_nxt;
    logic             w_f_wall_nxt;
    logic             w_f_bottom_nxt;
    logic [13:0]      r_score;
    logic [13:0]      w_score_nxt;
    logic [2:0]       r_lives;
    logic [2:0]       w_lives_nxt;
    logic             r_launch;
    logic             w_launch_nxt;
    logic [14:0]      w_score_sum;
    logic [13:0]      w_score_sat;
    logic             w_wall_hit;
    logic             w_stay_play;

    assign w_key_edge = key5IsPressed & ~r_key_prev;
    assign w_wall_hit = collisionSmileyBorderTop | collisionSmileyBorderLeft
                      | collisionSmileyBorderRight;

    // 15-bit sum so a near-max score cannot wrap before saturation is applied
    assign w_score_sum = {1'b0, r_score}
                       + (r_f_flip ? 15'(FLIPPER_POINTS) : 15'd0)
                       + (r_f_wall ? 15'(WALL_POINTS)    : 15'd0);
    assign w_score_sat = (w_score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_score_sum[13:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_score_nxt     = r_score;
        w_lives_nxt     = r_lives;
        w_launch_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_edge) begin
                    w_state_nxt     = ST_SERVE;
                    w_frame_cnt_nxt = CNT_W'(SERVE_FRAMES);
                end
            end
            ST_SERVE: begin
                if (w_key_edge) begin
                    w_state_nxt     = ST_PLAY;
                    w_frame_cnt_nxt = '0;
                    w_launch_nxt    = 1'b1;
                end else if (startOfFrame) begin
                    if (r_frame_cnt <= CNT_W'(1)) begin
                        w_state_nxt     = ST_PLAY;
                        w_frame_cnt_nxt = '0;
                        w_launch_nxt    = 1'b1;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt - CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // The finished frame is scored even when it also ends in a loss or pause
                if (startOfFrame) begin
                    w_score_nxt = w_score_sat;
                end
                if (w_key_edge) begin
                    w_state_nxt = ST_PAUSED;
                end else if (startOfFrame && r_f_bottom) begin
                    w_state_nxt     = ST_LOST;
                    w_frame_cnt_nxt = CNT_W'(LOST_FRAMES);
                    if (r_lives != 3'd0) begin
                        w_lives_nxt = r_lives - 3'd1;
                    end
                end
            end
            ST_PAUSED: begin
                if (w_key_edge) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_LOST: begin
                if (startOfFrame) begin
                    if (r_frame_cnt <= CNT_W'(1)) begin
                        if (r_lives == 3'd0) begin
                            w_state_nxt     = ST_GAME_OVER;
                            w_frame_cnt_nxt = '0;
                        end else begin
                            w_state_nxt     = ST_SERVE;
                            w_frame_cnt_nxt = CNT_W'(SERVE_FRAMES);
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt - CNT_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (w_key_edge) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_cnt_nxt = '0;
                    w_score_nxt     = '0;
                    w_lives_nxt     = 3'(LIVES);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Flags live only across an uninterrupted PLAY frame; a pulse coincident with
    // startOfFrame lands after the clear and counts toward the next frame.
    assign w_stay_play = (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY);

    always_comb begin
        w_f_flip_nxt   = 1'b0;
        w_f_wall_nxt   = 1'b0;
        w_f_bottom_nxt = 1'b0;
        if (w_stay_play) begin
            if (startOfFrame) begin
                w_f_flip_nxt   = collisionSmileyFlipper;
                w_f_wall_nxt   = w_wall_hit;
                w_f_bottom_nxt = collisionSmileyBorderBottom;
            end else begin
                w_f_flip_nxt   = r_f_flip   | collisionSmileyFlipper;
                w_f_wall_nxt   = r_f_wall   | w_wall_hit;
                w_f_bottom_nxt = r_f_bottom | collisionSmileyBorderBottom;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_key_prev  <= 1'b1;
            r_f_flip    <= 1'b0;
            r_f_wall    <= 1'b0;
            r_f_bottom  <= 1'b0;
            r_score     <= '0;
            r_lives     <= 3'(LIVES);
            r_launch    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_key_prev  <= key5IsPressed;
            r_f_flip    <= w_f_flip_nxt;
            r_f_wall    <= w_f_wall_nxt;
            r_f_bottom  <= w_f_bottom_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
            r_launch    <= w_launch_nxt;
        end
    end

    assign state       = r_state;
    assign pause       = (r_state != ST_PLAY);
    assign ballHold    = (r_state == ST_IDLE) || (r_state == ST_SERVE)
                      || (r_state == ST_LOST) || (r_state == ST_GAME_OVER);
    assign gameOver    = (r_state == ST_GAME_OVER);
    assign launchPulse = r_launch;
    assign score       = r_score;
    assign lives       = r_lives;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: serve, scoring, pause, loss, game over,
// saturation and asynchronous reset, with hand-computed expectations.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        key5IsPressed;
    logic        c_flip, c_top, c_left, c_right, c_bottom;
    logic        pause, ballHold, launchPulse, gameOver;
    logic [13:0] score;
    logic [2:0]  lives;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_PAUSED = 3'd3, S_LOST = 3'd4, S_OVER = 3'd5;

    game_sequencer dut (
        .clk                        (clk),
        .resetN                     (resetN),
        .startOfFrame               (startOfFrame),
        .key5IsPressed              (key5IsPressed),
        .collisionSmileyFlipper     (c_flip),
        .collisionSmileyBorderTop   (c_top),
        .collisionSmileyBorderLeft  (c_left),
        .collisionSmileyBorderRight (c_right),
        .collisionSmileyBorderBottom(c_bottom),
        .pause                      (pause),
        .ballHold                   (ballHold),
        .launchPulse                (launchPulse),
        .score                      (score),
        .lives                      (lives),
        .gameOver                   (gameOver),
        .state                      (state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the active edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
    endtask

    task automatic press_key();
        key5IsPressed = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        cycle();
    endtask

    task automatic frame(input int n_flip, input int n_top, input int n_left,
                         input int n_right, input int n_bottom);
        for (int i = 0; i < n_flip; i++) begin c_flip = 1'b1; cycle(); c_flip = 1'b0; end
        for (int i = 0; i < n_top; i++) begin c_top = 1'b1; cycle(); c_top = 1'b0; end
        for (int i = 0; i < n_left; i++) begin c_left = 1'b1; cycle(); c_left = 1'b0; end
        for (int i = 0; i < n_right; i++) begin c_right = 1'b1; cycle(); c_right = 1'b0; end
        for (int i = 0; i < n_bottom; i++) begin c_bottom = 1'b1; cycle(); c_bottom = 1'b0; end
        sof();
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; key5IsPressed = 1'b1;
        c_flip = 1'b0; c_top = 1'b0; c_left = 1'b0; c_right = 1'b0; c_bottom = 1'b0;
        repeat (3) cycle();
        n_cmp++;
        if ({state, lives, score, pause, ballHold, launchPulse, gameOver} !==
            {S_IDLE, 3'd3, 14'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: state=%0d lives=%0d score=%0d pause=%b hold=%b launch=%b over=%b required 0/3/0/1/1/0/0",
                     state, lives, score, pause, ballHold, launchPulse, gameOver);
        end
        resetN = 1'b1;
        repeat (3) cycle();
        n_cmp++;
        if (state !== S_IDLE) begin
            n_err++;
            $display("FAIL key_held_through_reset: state=%0d required %0d", state, S_IDLE);
        end
        key5IsPressed = 1'b0;
        cycle();
        n_cmp++;
        if (state !== S_IDLE) begin
            n_err++;
            $display("FAIL key_release_idle: state=%0d required %0d", state, S_IDLE);
        end
    endtask

    task automatic test_serve();
        press_key();
        n_cmp++;
        if (state !== S_SERVE || ballHold !== 1'b1) begin
            n_err++;
            $display("FAIL serve_entry: state=%0d hold=%b required %0d/1", state, ballHold, S_SERVE);
        end
        repeat (59) sof();
        n_cmp++;
        if (state !== S_SERVE) begin
            n_err++;
            $display("FAIL serve_59_frames: state=%0d required %0d", state, S_SERVE);
        end
        sof();
        n_cmp++;
        if (state !== S_PLAY || launchPulse !== 1'b1 || pause !== 1'b0 || ballHold !== 1'b0) begin
            n_err++;
            $display("FAIL serve_release: state=%0d launch=%b pause=%b hold=%b required %0d/1/0/0",
                     state, launchPulse, pause, ballHold, S_PLAY);
        end
        cycle();
        n_cmp++;
        if (launchPulse !== 1'b0) begin
            n_err++;
            $display("FAIL launch_width: launch=%b required 0", launchPulse);
        end
    endtask

    task automatic test_scoring();
        frame(40, 5, 0, 0, 0);
        n_cmp++;
        if (score !== 14'd11) begin
            n_err++;
            $display("FAIL score_flip_top: score=%0d required 11", score);
        end
        frame(0, 0, 0, 0, 0);
        n_cmp++;
        if (score !== 14'd11) begin
            n_err++;
            $display("FAIL score_empty_frame: score=%0d required 11", score);
        end
        frame(0, 0, 3, 2, 0);
        n_cmp++;
        if (score !== 14'd12) begin
            n_err++;
            $display("FAIL score_left_right: score=%0d required 12", score);
        end
        c_flip = 1'b1;
        sof();
        c_flip = 1'b0;
        n_cmp++;
        if (score !== 14'd12) begin
            n_err++;
            $display("FAIL pulse_with_sof_now: score=%0d required 12", score);
        end
        sof();
        n_cmp++;
        if (score !== 14'd22) begin
            n_err++;
            $display("FAIL pulse_with_sof_next: score=%0d required 22", score);
        end
    endtask

    task automatic test_pause();
        press_key();
        n_cmp++;
        if (state !== S_PAUSED || pause !== 1'b1 || ballHold !== 1'b0) begin
            n_err++;
            $display("FAIL pause_entry: state=%0d pause=%b hold=%b required %0d/1/0",
                     state, pause, ballHold, S_PAUSED);
        end
        frame(4, 2, 0, 0, 1);
        n_cmp++;
        if (score !== 14'd22 || state !== S_PAUSED) begin
            n_err++;
            $display("FAIL paused_ignores: score=%0d state=%0d required 22/%0d", score, state, S_PAUSED);
        end
        key5IsPressed = 1'b1;
        cycle();
        n_cmp++;
        if (state !== S_PLAY || launchPulse !== 1'b0) begin
            n_err++;
            $display("FAIL resume: state=%0d launch=%b required %0d/0", state, launchPulse, S_PLAY);
        end
        key5IsPressed = 1'b0;
        cycle();
        sof();
        n_cmp++;
        if (score !== 14'd22 || state !== S_PLAY) begin
            n_err++;
            $display("FAIL resume_no_stale: score=%0d state=%0d required 22/%0d", score, state, S_PLAY);
        end
    endtask

    task automatic test_loss();
        frame(1, 0, 0, 0, 1);
        n_cmp++;
        if (state !== S_LOST || lives !== 3'd2 || score !== 14'd32 || ballHold !== 1'b1) begin
            n_err++;
            $display("FAIL loss: state=%0d lives=%0d score=%0d hold=%b required %0d/2/32/1",
                     state, lives, score, ballHold, S_LOST);
        end
        repeat (89) sof();
        n_cmp++;
        if (state !== S_LOST) begin
            n_err++;
            $display("FAIL lost_89_frames: state=%0d required %0d", state, S_LOST);
        end
        sof();
        n_cmp++;
        if (state !== S_SERVE || lives !== 3'd2) begin
            n_err++;
            $display("FAIL lost_to_serve: state=%0d lives=%0d required %0d/2", state, lives, S_SERVE);
        end
        // Key and frame pulse together: key wins and releases the ball
        key5IsPressed = 1'b1;
        startOfFrame = 1'b1;
        cycle();
        key5IsPressed = 1'b0;
        startOfFrame = 1'b0;
        n_cmp++;
        if (state !== S_PLAY || launchPulse !== 1'b1) begin
            n_err++;
            $display("FAIL key_sof_serve: state=%0d launch=%b required %0d/1", state, launchPulse, S_PLAY);
        end
        cycle();
    endtask

    task automatic test_game_over();
        frame(0, 0, 0, 0, 1);
        repeat (90) sof();
        press_key();
        frame(0, 0, 0, 0, 1);
        n_cmp++;
        if (state !== S_LOST || lives !== 3'd0) begin
            n_err++;
            $display("FAIL last_ball: state=%0d lives=%0d required %0d/0", state, lives, S_LOST);
        end
        repeat (90) sof();
        n_cmp++;
        if (state !== S_OVER || gameOver !== 1'b1 || lives !== 3'd0 || score !== 14'd32) begin
            n_err++;
            $display("FAIL game_over: state=%0d over=%b lives=%0d score=%0d required %0d/1/0/32",
                     state, gameOver, lives, score, S_OVER);
        end
        press_key();
        n_cmp++;
        if (state !== S_IDLE || score !== 14'd0 || lives !== 3'd3 || gameOver !== 1'b0) begin
            n_err++;
            $display("FAIL restart: state=%0d score=%0d lives=%0d over=%b required 0/0/3/0",
                     state, score, lives, gameOver);
        end
    endtask

    task automatic test_saturation();
        press_key();
        press_key();
        repeat (999) frame(1, 0, 0, 0, 0);
        n_cmp++;
        if (score !== 14'd9990) begin
            n_err++;
            $display("FAIL score_9990: score=%0d required 9990", score);
        end
        frame(0, 1, 0, 0, 0);
        frame(0, 0, 1, 0, 0);
        frame(0, 0, 0, 1, 0);
        frame(0, 1, 1, 1, 0);
        frame(0, 2, 0, 0, 0);
        n_cmp++;
        if (score !== 14'd9995) begin
            n_err++;
            $display("FAIL score_9995: score=%0d required 9995", score);
        end
        frame(1, 0, 0, 0, 0);
        n_cmp++;
        if (score !== 14'd9999) begin
            n_err++;
            $display("FAIL score_saturate: score=%0d required 9999", score);
        end
        frame(3, 1, 0, 0, 0);
        n_cmp++;
        if (score !== 14'd9999) begin
            n_err++;
            $display("FAIL score_hold_max: score=%0d required 9999", score);
        end
    endtask

    task automatic test_async_reset();
        n_cmp++;
        if (state !== S_PLAY) begin
            n_err++;
            $display("FAIL pre_reset_play: state=%0d required %0d", state, S_PLAY);
        end
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++;
        if (state !== S_IDLE || launchPulse !== 1'b0 || score !== 14'd0 || lives !== 3'd3) begin
            n_err++;
            $display("FAIL async_reset: state=%0d launch=%b score=%0d lives=%0d required 0/0/0/3",
                     state, launchPulse, score, lives);
        end
        cycle();
        resetN = 1'b1;
        cycle();
        n_cmp++;
        if (state !== S_IDLE) begin
            n_err++;
            $display("FAIL after_reset_idle: state=%0d required %0d", state, S_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_scoring();
        test_pause();
        test_loss();
        test_game_over();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
